// File: rtl/if_fetch_unit.sv
// IF-stage front half: owns the program counter, drives instruction memory
// and registers the fetched word into the IF/ID pipeline register.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4,
  parameter logic [31:0] MEM_BYTES = 32'd128,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_instr,
  output logic        ifid_valid,
  output logic        fetch_fault
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        fetch_fault_q, fetch_fault_d;
  logic        in_range_s;

  assign in_range_s = (pc_q <= (MEM_BYTES - 32'd4));

  // Next-state: redirect beats stall; an out-of-range fetch parks the pc and latches the fault.
  always_comb begin
    pc_d            = pc_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_valid_d    = ifid_valid_q;
    fetch_fault_d   = fetch_fault_q;
    if (redirect) begin
      pc_d         = {redirect_pc[31:2], 2'b00};
      ifid_valid_d = 1'b0;
      ifid_instr_d = NOP_WORD;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (in_range_s) begin
      ifid_instr_d    = imem_data;
      ifid_pc_d       = pc_q;
      ifid_pc_plus4_d = pc_q + PC_STEP;
      ifid_valid_d    = 1'b1;
      pc_d            = pc_q + PC_STEP;
    end else begin
      fetch_fault_d = 1'b1;
      ifid_valid_d  = 1'b0;
      ifid_instr_d  = NOP_WORD;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      ifid_pc_q       <= 32'h0000_0000;
      ifid_pc_plus4_q <= 32'h0000_0000;
      ifid_instr_q    <= NOP_WORD;
      ifid_valid_q    <= 1'b0;
      fetch_fault_q   <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_valid_q    <= ifid_valid_d;
      fetch_fault_q   <= fetch_fault_d;
    end
  end

  assign imem_addr     = pc_q;
  assign ifid_pc       = ifid_pc_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_instr    = ifid_instr_q;
  assign ifid_valid    = ifid_valid_q;
  assign fetch_fault   = fetch_fault_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a rule-level fetch model predicts every
// edge, a negedge monitor compares, plus directed checks from the test plan.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_data;
  logic [31:0] ifid_pc, ifid_pc_plus4, ifid_instr;
  logic        ifid_valid, fetch_fault;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem [0:31];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] ip4;
    logic [31:0] instr;
    logic        v;
    logic        f;
  } exp_t;

  exp_t model;
  exp_t expq [$];

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4), .ifid_instr(ifid_instr),
    .ifid_valid(ifid_valid), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory: combinational read, garbage outside the window.
  assign imem_data = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'hBAD0_BAD0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive at negedge, then advance the model at the posedge.
  task automatic cycle(input logic r, input logic s, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; stall = s; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      model = '{pc: 32'h0, ipc: 32'h0, ip4: 32'h0, instr: 32'h0, v: 1'b0, f: 1'b0};
    end else if (rd) begin
      model.pc    = rpc & 32'hFFFF_FFFC;
      model.v     = 1'b0;
      model.instr = 32'h0;
    end else if (!s) begin
      if (model.pc <= 32'd124) begin
        model.instr = mem[model.pc >> 2];
        model.ipc   = model.pc;
        model.ip4   = model.pc + 32'd4;
        model.v     = 1'b1;
        model.pc    = model.pc + 32'd4;
      end else begin
        model.f     = 1'b1;
        model.v     = 1'b0;
        model.instr = 32'h0;
      end
    end
    expq.push_back(model);
    #1;
  endtask

  // Monitor: every negedge, compare DUT outputs with the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        cmp("sb_imem_addr", imem_addr, e.pc);
        cmp("sb_ifid_pc", ifid_pc, e.ipc);
        cmp("sb_ifid_pc_plus4", ifid_pc_plus4, e.ip4);
        cmp("sb_ifid_instr", ifid_instr, e.instr);
        cmp("sb_ifid_valid", {31'd0, ifid_valid}, {31'd0, e.v});
        cmp("sb_fetch_fault", {31'd0, fetch_fault}, {31'd0, e.f});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rpc;
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0]  = 32'hA000_00AA;
    mem[1]  = 32'h1000_0011;
    mem[2]  = 32'h2000_0022;
    mem[8]  = 32'h8000_0088;
    mem[31] = 32'h7C00_007C;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    model = '0;

    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0);
    cmp("rst_valid", {31'd0, ifid_valid}, 32'd0);
    cmp("rst_instr", ifid_instr, 32'h0);
    cmp("rst_addr", imem_addr, 32'h0);

    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp("seq0_instr", ifid_instr, 32'hA000_00AA);
    cmp("seq0_pc", ifid_pc, 32'd0);
    cmp("seq0_pc4", ifid_pc_plus4, 32'd4);
    cmp("seq0_valid", {31'd0, ifid_valid}, 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp("seq1_instr", ifid_instr, 32'h1000_0011);
    cmp("seq1_pc", ifid_pc, 32'd4);
    cmp("seq1_pc4", ifid_pc_plus4, 32'd8);

    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 32'h0);
      cmp("stall_instr", ifid_instr, 32'h1000_0011);
      cmp("stall_addr", imem_addr, 32'd8);
    end
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp("post_stall_instr", ifid_instr, 32'h2000_0022);
    cmp("post_stall_pc", ifid_pc, 32'd8);
    cmp("post_stall_pc4", ifid_pc_plus4, 32'd12);

    cycle(1'b0, 1'b1, 1'b1, 32'h22);
    cmp("redir_addr", imem_addr, 32'h20);
    cmp("redir_valid", {31'd0, ifid_valid}, 32'd0);
    cmp("redir_instr", ifid_instr, 32'h0);
    cmp("redir_pc_kept", ifid_pc, 32'd8);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp("redir_cap_instr", ifid_instr, 32'h8000_0088);
    cmp("redir_cap_pc", ifid_pc, 32'h20);

    cycle(1'b0, 1'b0, 1'b1, 32'd124);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp("edge_instr", ifid_instr, 32'h7C00_007C);
    cmp("edge_valid", {31'd0, ifid_valid}, 32'd1);
    cmp("edge_addr", imem_addr, 32'd128);
    cmp("edge_fault", {31'd0, fetch_fault}, 32'd0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp("oor_fault", {31'd0, fetch_fault}, 32'd1);
    cmp("oor_valid", {31'd0, ifid_valid}, 32'd0);
    cmp("oor_addr_hold", imem_addr, 32'd128);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp("oor_addr_hold2", imem_addr, 32'd128);
    cycle(1'b0, 1'b0, 1'b1, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 32'h0);
    cmp("resume_instr", ifid_instr, 32'hA000_00AA);
    cmp("resume_valid", {31'd0, ifid_valid}, 32'd1);
    cmp("sticky_fault", {31'd0, fetch_fault}, 32'd1);

    cycle(1'b0, 1'b0, 1'b1, 32'd20);
    cmp("pre_rst_addr", imem_addr, 32'd20);
    cycle(1'b1, 1'b1, 1'b1, 32'h40);
    cmp("mid_rst_addr", imem_addr, 32'h0);
    cmp("mid_rst_pc", ifid_pc, 32'h0);
    cmp("mid_rst_pc4", ifid_pc_plus4, 32'h0);
    cmp("mid_rst_instr", ifid_instr, 32'h0);
    cmp("mid_rst_valid", {31'd0, ifid_valid}, 32'd0);
    cmp("mid_rst_fault", {31'd0, fetch_fault}, 32'd0);

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 7) == 0) rpc = $urandom;
      else rpc = $urandom_range(0, 140);
      cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0), rpc);
    end

    @(negedge clk);
    @(negedge clk);
    cmp("queue_drained", expq.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
